// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and
// the hard-wired zero register number.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: counts up on i_inc and sticks at all-ones.
module pipe_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count qualifying cycles, holding at the maximum instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: memory-wait freeze,
// branch/jump redirects, load-use bubbles, and stall/flush statistics.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_mem_read,
    input  logic             mem_mem_write,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             memwb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              r_mem_err;

    logic w_mem_acc;
    logic w_load_use;
    logic w_wait_last;
    logic w_release;
    logic w_freeze;
    logic w_timeout;
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_mem_acc   = mem_mem_read || mem_mem_write;
    // A load writing $zero never creates a real dependency.
    assign w_load_use  = ex_mem_read && (ex_rt != REG_ZERO) &&
                         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign w_wait_last = (r_wait_cnt == WAIT_LAST);
    assign w_release   = (r_state == MEM_WAIT) && (dmem_ready || w_wait_last);
    // Ready arriving on the last wait cycle is a normal completion, not a timeout.
    assign w_timeout   = (r_state == MEM_WAIT) && !dmem_ready && w_wait_last;
    assign w_freeze    = ((r_state == RUN) && w_mem_acc && !dmem_ready) ||
                         ((r_state == MEM_WAIT) && !w_release);

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    // Next-state: enter MEM_WAIT on an unready access, leave on ready or watchdog
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        case (r_state)
            RUN: begin
                if (w_mem_acc && !dmem_ready) begin
                    w_state_nxt = MEM_WAIT;
                    w_wait_nxt  = '0;
                end
            end
            MEM_WAIT: begin
                if (w_release) begin
                    w_state_nxt = RUN;
                    w_wait_nxt  = '0;
                end else begin
                    w_wait_nxt  = r_wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // Outputs: memory freeze dominates, then branch, load-use, jump
    always_comb begin
        dmem_req     = 1'b0;
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        ifid_flush   = 1'b0;
        idex_we      = 1'b0;
        idex_flush   = 1'b0;
        exmem_we     = 1'b0;
        memwb_bubble = 1'b0;
        if (!reset) begin
            dmem_req = (r_state == MEM_WAIT) || w_mem_acc;
            if (w_freeze) begin
                // Redirects are held off until the access completes.
                memwb_bubble = 1'b1;
            end else begin
                pc_we    = 1'b1;
                ifid_we  = 1'b1;
                idex_we  = 1'b1;
                exmem_we = 1'b1;
                if (ex_branch_taken) begin
                    // ID holds a wrong-path instruction, so its hazards are moot.
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (w_load_use) begin
                    // Hold the jump in ID; it is re-decoded next cycle.
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                end else if (id_jump) begin
                    ifid_flush = 1'b1;
                end
            end
        end
    end

    assign mem_err     = r_mem_err;
    assign w_stall_inc = !reset && !pc_we;
    assign w_flush_inc = ifid_flush || idex_flush;

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_stall_inc),
        .o_count (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_flush_inc),
        .o_count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a table of single-cycle hazard vectors plus
// hand-written sequences for memory waits, timeout, saturation and reset.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, id_jump, ex_mem_read, ex_branch_taken;
    logic        mem_mem_read, mem_mem_write, dmem_ready;

    logic        dmem_req, pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
    logic        exmem_we, memwb_bubble, mem_err;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_dmem_req, s_pc_we, s_ifid_we, s_ifid_flush, s_idex_we, s_idex_flush;
    logic        s_exmem_we, s_memwb_bubble, s_mem_err;
    logic [2:0]  s_stall_cnt, s_flush_cnt;

    logic [7:0]  w_out;

    int total = 0;
    int bad   = 0;

    // Output order: req pc_we ifid_we ifid_flush idex_we idex_flush exmem_we bubble
    localparam logic [7:0] O_IDLE   = 8'b0110_1010;
    localparam logic [7:0] O_LU     = 8'b0000_1110;
    localparam logic [7:0] O_BR     = 8'b0111_1110;
    localparam logic [7:0] O_JMP    = 8'b0111_1010;
    localparam logic [7:0] O_FROZEN = 8'b1000_0001;
    localparam logic [7:0] O_REL    = 8'b1110_1010;
    localparam logic [7:0] O_RST    = 8'b0000_0000;

    always #5 clk = ~clk;

    assign w_out = {dmem_req, pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_bubble};

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .dmem_ready(dmem_ready), .dmem_req(dmem_req),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
        .idex_flush(idex_flush), .exmem_we(exmem_we), .memwb_bubble(memwb_bubble),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.MEM_TIMEOUT(64), .CNT_W(3)) u_sat (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .dmem_ready(dmem_ready), .dmem_req(s_dmem_req),
        .pc_we(s_pc_we), .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush), .idex_we(s_idex_we),
        .idex_flush(s_idex_flush), .exmem_we(s_exmem_we), .memwb_bubble(s_memwb_bubble),
        .mem_err(s_mem_err), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       jump;
        logic       exmr;
        logic [4:0] exrt;
        logic       br;
        logic       mr;
        logic       mw;
        logic       rdy;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_jump = 1'b0;
        ex_mem_read = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0;
        mem_mem_read = 1'b0; mem_mem_write = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic set_in(input vec_t v);
        id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt; id_jump = v.jump;
        ex_mem_read = v.exmr; ex_rt = v.exrt; ex_branch_taken = v.br;
        mem_mem_read = v.mr; mem_mem_write = v.mw; dmem_ready = v.rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                name         rs     rt     ur    jmp   exmr  exrt   br    mr    mw    rdy   expected
        vecs[0]  = '{"idle",        5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
        vecs[1]  = '{"lu_rs",       5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[2]  = '{"lu_zero_reg", 5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
        vecs[3]  = '{"lu_rt",       5'd3,  5'd7,  1'b1, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[4]  = '{"lu_rt_unused",5'd3,  5'd7,  1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
        vecs[5]  = '{"no_load",     5'd5,  5'd5,  1'b1, 1'b0, 1'b0, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
        vecs[6]  = '{"br_over_lu",  5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, O_BR};
        vecs[7]  = '{"jump",        5'd1,  5'd2,  1'b1, 1'b1, 1'b0, 5'd9,  1'b0, 1'b0, 1'b0, 1'b0, O_JMP};
        vecs[8]  = '{"lu_over_jmp", 5'd9,  5'd2,  1'b1, 1'b1, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[9]  = '{"br_over_jmp", 5'd1,  5'd2,  1'b0, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, O_BR};
        vecs[10] = '{"rd_zero_wait",5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, O_REL};
        vecs[11] = '{"wr_zw_jump",  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 8'b1111_1010};
        vecs[12] = '{"ready_only",  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, O_IDLE};

        // Reset state
        idle_in();
        reset = 1'b1;
        #2;
        chk("rst_outputs", 32'(w_out), 32'(O_RST));
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("run_idle", 32'(w_out), 32'(O_IDLE));
        chk("run_stall_cnt", stall_cnt, 32'd0);
        chk("run_flush_cnt", flush_cnt, 32'd0);

        // Single-cycle hazard table
        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1;
            set_in(vecs[i]);
            @(negedge clk);
            chk(vecs[i].name, 32'(w_out), 32'(vecs[i].exp));
        end
        @(posedge clk);
        #1;
        idle_in();
        @(negedge clk);
        chk("tbl_stall_cnt", stall_cnt, 32'd3);
        chk("tbl_flush_cnt", flush_cnt, 32'd7);

        // Counter saturation on the 3-bit instance
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
        end
        @(posedge clk);
        #1;
        idle_in();
        @(negedge clk);
        chk("sat_stall_wide", stall_cnt, 32'd10);
        chk("sat_flush_wide", flush_cnt, 32'd10);
        chk("sat_stall_narrow", 32'(s_stall_cnt), 32'd7);
        chk("sat_flush_narrow", 32'(s_flush_cnt), 32'd7);

        // Multi-cycle read: ready low for 3 cycles then high
        do_reset();
        @(posedge clk);
        #1;
        mem_mem_read = 1'b1; dmem_ready = 1'b0;
        ex_branch_taken = 1'b1; id_jump = 1'b1;
        @(negedge clk);
        chk("mw_stall_defers_br", 32'(w_out), 32'(O_FROZEN));
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            ex_branch_taken = 1'b0; id_jump = 1'b0;
            @(negedge clk);
            chk("mw_wait_frozen", 32'(w_out), 32'(O_FROZEN));
        end
        @(posedge clk);
        #1;
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("mw_release", 32'(w_out), 32'(O_REL));
        @(posedge clk);
        #1;
        idle_in();
        @(negedge clk);
        chk("mw_after_idle", 32'(w_out), 32'(O_IDLE));
        chk("mw_stall_cnt", stall_cnt, 32'd3);
        chk("mw_flush_cnt", flush_cnt, 32'd0);
        chk("mw_no_err", 32'(mem_err), 32'd0);

        // Watchdog timeout with MEM_TIMEOUT=4
        do_reset();
        @(posedge clk);
        #1;
        mem_mem_write = 1'b1; dmem_ready = 1'b0;
        @(negedge clk);
        chk("to_first_frozen", 32'(w_out), 32'(O_FROZEN));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("to_wait_frozen", 32'(w_out), 32'(O_FROZEN));
        end
        @(posedge clk);
        @(negedge clk);
        chk("to_release", 32'(w_out), 32'(O_REL));
        chk("to_err_not_yet", 32'(mem_err), 32'd0);
        @(posedge clk);
        #1;
        idle_in();
        @(negedge clk);
        chk("to_err_set", 32'(mem_err), 32'd1);
        chk("to_after_idle", 32'(w_out), 32'(O_IDLE));
        chk("to_stall_cnt", stall_cnt, 32'd4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("to_err_sticky", 32'(mem_err), 32'd1);

        // Reset in the middle of MEM_WAIT, then a clean handshake
        @(posedge clk);
        #1;
        mem_mem_read = 1'b1; dmem_ready = 1'b0;
        @(negedge clk);
        chk("rw_frozen", 32'(w_out), 32'(O_FROZEN));
        @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rw_rst_outputs", 32'(w_out), 32'(O_RST));
        chk("rw_rst_err", 32'(mem_err), 32'd0);
        chk("rw_rst_stall", stall_cnt, 32'd0);
        chk("rw_rst_flush", flush_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rw_restart_req", 32'(w_out), 32'(O_FROZEN));
        @(posedge clk);
        @(negedge clk);
        chk("rw_restart_wait", 32'(w_out), 32'(O_FROZEN));
        chk("rw_restart_stall", stall_cnt, 32'd1);
        @(posedge clk);
        #1;
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("rw_restart_release", 32'(w_out), 32'(O_REL));
        @(posedge clk);
        #1;
        idle_in();
        @(negedge clk);
        chk("rw_final_idle", 32'(w_out), 32'(O_IDLE));
        chk("rw_final_stall", stall_cnt, 32'd2);
        chk("rw_final_err", 32'(mem_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
